sync_fifo_stream_reader: RTL

Read-side companion for the team's synchronous FIFO (`sm_sync_fifo`). It pops words from the FIFO read port (`rd_en` / `data_out` / `empty`) and presents them as a valid/ready stream to a downstream consumer. A 2-entry skid buffer absorbs the FIFO's one-cycle registered read latency, so the block never drops or duplicates a word and sustains one word per cycle. A wrapping counter reports how many words have been delivered.

---
 rtl/sync_fifo_stream_reader_if.sv | 44 ++++
 rtl/sync_fifo_stream_reader.sv | 105 ++++++++++
 2 files changed

// File: rtl/sync_fifo_stream_reader_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_stream_reader_if
//
// Bundles the two sides of the FIFO stream reader:
//   FIFO read port : fifo_empty (in), fifo_rd_en (out), fifo_rd_data (in)
//   Output stream  : m_valid (out), m_data (out), m_ready (in)
//   Status         : words_out (out), count of accepted output words
//
// Modports:
//   master - the reader itself (drives rd_en, the stream and the counter)
//   slave  - the environment (FIFO plus downstream consumer)
// -----------------------------------------------------------------------------
interface sync_fifo_stream_reader_if #(
    parameter int DW = 8,
    parameter int CW = 16
);
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [CW-1:0] words_out;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output words_out
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  words_out
    );
endinterface

// File: rtl/sync_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// sync_fifo_stream_reader
//
// Pops words from a synchronous FIFO read port and presents them as a
// valid/ready stream. The FIFO returns data one cycle after rd_en, so a
// 2-entry skid buffer holds words that are already on their way while the
// consumer stalls. A read is only issued when a buffer slot is guaranteed,
// so no word is ever dropped or duplicated, and one word per cycle is
// sustained when the consumer is always ready.
//
// Ports:
//   clk   - single clock, rising edge
//   rstn  - asynchronous, active-low reset
//   bus   - sync_fifo_stream_reader_if.master
//             fifo_empty / fifo_rd_en / fifo_rd_data : FIFO read port
//             m_valid / m_data / m_ready             : output stream
//             words_out                              : accepted-word counter (wraps)
// -----------------------------------------------------------------------------
module sync_fifo_stream_reader #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    sync_fifo_stream_reader_if.master bus
);

    // Skid buffer and bookkeeping
    logic [DW-1:0] r_buf [2];
    logic          r_rd_ptr;
    logic          r_wr_ptr;
    logic [1:0]    r_occ;
    logic          r_valid;     // mirrors (r_occ != 0), kept as its own flop
    logic          r_inflight;  // FIFO data arrives this cycle
    logic [CW-1:0] r_words_out;

    logic          w_accept;
    logic          w_capture;
    logic          w_rd_en;
    logic [2:0]    w_pending;
    logic [1:0]    w_occ_nxt;

    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so
        // no path can leave one unassigned and infer a latch.
        w_accept  = r_valid & bus.m_ready;
        w_capture = r_inflight;
        w_occ_nxt = r_occ;

        // Credit check: words already held plus the one in flight, minus the
        // one leaving this cycle, must leave a free slot for a new read.
        w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_accept};
        // rstn gates the read so the FIFO is never popped while held in reset.
        w_rd_en   = rstn & ~bus.fifo_empty & (w_pending < 3'd2);

        if (w_capture && !w_accept) begin
            w_occ_nxt = r_occ + 2'd1;
        end else if (!w_capture && w_accept) begin
            w_occ_nxt = r_occ - 2'd1;
        end
    end

    // Control state: pointers, occupancy, in-flight flag, counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_occ       <= 2'd0;
            r_valid     <= 1'b0;
            r_inflight  <= 1'b0;
            r_words_out <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            r_inflight <= w_rd_en;
            r_occ      <= w_occ_nxt;
            r_valid    <= (w_occ_nxt != 2'd0);
            if (w_capture) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_accept) begin
                r_rd_ptr    <= ~r_rd_ptr;
                r_words_out <= r_words_out + CW'(1);
            end
        end
    end

    // Buffer storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: this small storage array is reset on purpose: m_data is
            // read straight from it and must show 0 during and after reset.
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else if (w_capture) begin
            r_buf[r_wr_ptr] <= bus.fifo_rd_data;
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = r_valid;
    assign bus.m_data     = r_buf[r_rd_ptr];
    assign bus.words_out  = r_words_out;

endmodule
